axis_1bit_frame_arbiter: RTL and testbench

AXIS_1BIT_FRAME_ARBITER -- requirements
Module: axis_1bit_frame_arbiter

---
 rtl/axis_1bit_frame_arbiter_pkg.sv | 21 ++
 rtl/axis_1bit_frame_arbiter_if.sv | 15 +
 rtl/axis_1bit_frame_arbiter_tracker.sv | 71 +++++++
 rtl/axis_1bit_frame_arbiter.sv | 120 ++++++++++++
 tb/tb_axis_1bit_frame_arbiter.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_1bit_frame_arbiter_pkg.sv
// Shared definitions for the 1-bit AXI-Stream frame arbiter.
//   arb_state_e          : arbiter FSM state encoding (IDLE, GRANT0, GRANT1)
//   DEFAULT_OVERSAMPLE   : samples per symbol, shared with the downstream decimator
//   DEFAULT_IDLE_TIMEOUT : granted-source silence (in cycles) before forced release
//   cnt_width()          : counter width helper that never returns zero
package axis_1bit_frame_arbiter_pkg;

    localparam int DEFAULT_OVERSAMPLE   = 4;
    localparam int DEFAULT_IDLE_TIMEOUT = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_e;

    function automatic int cnt_width(input int max_val);
        return (max_val > 1) ? $clog2(max_val) : 1;
    endfunction

endpackage

// File: rtl/axis_1bit_frame_arbiter_if.sv
// 1-bit AXI-Stream bundle used on every stream port of the arbiter.
//   tdata  : oversampled data bit
//   tvalid : beat valid
//   tready : sink ready
//   tlast  : last-symbol marker
// master drives tdata/tvalid/tlast and samples tready; slave is the mirror.
interface axis_1bit;
    logic tdata;
    logic tvalid;
    logic tready;
    logic tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_1bit_frame_arbiter_tracker.sv
// Frame tracker for the currently granted source.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_active       : a grant is held this cycle; low clears both counters
//   i_tvalid/i_tlast : granted source's valid/last
//   i_tready       : shared sink ready
//   o_frame_end    : accepted tlast beat on the final sample of a symbol
//   o_timeout      : this is the IDLE_TIMEOUT-th consecutive silent grant cycle
module axis_1bit_frame_tracker
    import axis_1bit_frame_arbiter_pkg::*;
#(
    parameter int OVERSAMPLE   = DEFAULT_OVERSAMPLE,
    parameter int IDLE_TIMEOUT = DEFAULT_IDLE_TIMEOUT
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_active,
    input  logic i_tvalid,
    input  logic i_tready,
    input  logic i_tlast,
    output logic o_frame_end,
    output logic o_timeout
);

    localparam int SYM_W = cnt_width(OVERSAMPLE);
    localparam int IDL_W = cnt_width(IDLE_TIMEOUT + 1);
    localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(OVERSAMPLE - 1);
    localparam logic [IDL_W-1:0] IDL_MAX  = IDL_W'(IDLE_TIMEOUT);
    localparam logic [IDL_W-1:0] IDL_PRE  = IDL_W'(IDLE_TIMEOUT - 1);

    logic [SYM_W-1:0] sym_q, sym_d;
    logic [IDL_W-1:0] idle_q, idle_d;
    logic             beat_acc;

    assign beat_acc = i_active & i_tvalid & i_tready;

    // Counters are held at zero while idle, so every grant starts clean.
    always_comb begin
        sym_d  = sym_q;
        idle_d = idle_q;
        if (!i_active) begin
            sym_d  = '0;
            idle_d = '0;
        end else begin
            if (beat_acc) begin
                sym_d = (sym_q == SYM_LAST) ? '0 : sym_q + SYM_W'(1);
            end
            // A stalled sink with valid data is not silence.
            if (i_tvalid) begin
                idle_d = '0;
            end else if (idle_q != IDL_MAX) begin
                idle_d = idle_q + IDL_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sym_q  <= '0;
            idle_q <= '0;
        end else begin
            sym_q  <= sym_d;
            idle_q <= idle_d;
        end
    end

    assign o_frame_end = beat_acc & i_tlast & (sym_q == SYM_LAST);
    // Fires on the cycle the counter is about to reach IDLE_TIMEOUT, so the
    // release happens on exactly the IDLE_TIMEOUT-th silent cycle.
    assign o_timeout   = i_active & ~i_tvalid & (idle_q == IDL_PRE);

endmodule

// File: rtl/axis_1bit_frame_arbiter.sv
// Two-requester frame arbiter for 1-bit oversampled AXI-Stream.
//   i_clk, i_rst_n : clock, async active-low reset
//   s0_axis, s1_axis : requester streams (slave side)
//   m_axis         : shared stream toward the decimator/correlator
//   o_grant        : one-hot grant {s1, s0}; 2'b00 when idle
//   o_timeout_err  : one-cycle pulse on forced release after source silence
//
// state  | meaning
// IDLE   | no grant; sink sees tvalid=0, both sources stalled
// GRANT0 | s0 passed through to m_axis until frame end or timeout
// GRANT1 | s1 passed through to m_axis until frame end or timeout
module axis_1bit_frame_arbiter
    import axis_1bit_frame_arbiter_pkg::*;
#(
    parameter int OVERSAMPLE   = DEFAULT_OVERSAMPLE,
    parameter int IDLE_TIMEOUT = DEFAULT_IDLE_TIMEOUT
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    axis_1bit.slave    s0_axis,
    axis_1bit.slave    s1_axis,
    axis_1bit.master   m_axis,
    output logic [1:0] o_grant,
    output logic       o_timeout_err
);

    arb_state_e state_q, state_d;
    // Source preferred when both request: 0 -> s0, 1 -> s1.
    logic       ptr_q, ptr_d;

    logic g_tdata, g_tvalid, g_tlast;
    logic rdy0, rdy1;
    logic frame_end, timeout;

    always_comb begin
        g_tdata  = 1'b0;
        g_tvalid = 1'b0;
        g_tlast  = 1'b0;
        rdy0     = 1'b0;
        rdy1     = 1'b0;
        case (state_q)
            GRANT0: begin
                g_tdata  = s0_axis.tdata;
                g_tvalid = s0_axis.tvalid;
                g_tlast  = s0_axis.tlast;
                rdy0     = m_axis.tready;
            end
            GRANT1: begin
                g_tdata  = s1_axis.tdata;
                g_tvalid = s1_axis.tvalid;
                g_tlast  = s1_axis.tlast;
                rdy1     = m_axis.tready;
            end
            default: ;
        endcase
    end

    assign m_axis.tdata   = g_tdata;
    assign m_axis.tvalid  = g_tvalid;
    assign m_axis.tlast   = g_tlast;
    assign s0_axis.tready = rdy0;
    assign s1_axis.tready = rdy1;

    axis_1bit_frame_tracker #(
        .OVERSAMPLE   (OVERSAMPLE),
        .IDLE_TIMEOUT (IDLE_TIMEOUT)
    ) u_tracker (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_active    (state_q != IDLE),
        .i_tvalid    (g_tvalid),
        .i_tready    (m_axis.tready),
        .i_tlast     (g_tlast),
        .o_frame_end (frame_end),
        .o_timeout   (timeout)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (s0_axis.tvalid && s1_axis.tvalid) begin
                    state_d = ptr_q ? GRANT1 : GRANT0;
                end else if (s0_axis.tvalid) begin
                    state_d = GRANT0;
                end else if (s1_axis.tvalid) begin
                    state_d = GRANT1;
                end
            end
            GRANT0: begin
                if (frame_end || timeout) begin
                    state_d = IDLE;
                    ptr_d   = 1'b1;
                end
            end
            GRANT1: begin
                if (frame_end || timeout) begin
                    state_d = IDLE;
                    ptr_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    assign o_grant       = {state_q == GRANT1, state_q == GRANT0};
    assign o_timeout_err = timeout;

endmodule

// File: tb/tb_axis_1bit_frame_arbiter.sv
module tb_axis_1bit_frame_arbiter;
    localparam int OS = 4;
    localparam int TO = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] grant;
    logic       to_err;
    logic       rdy = 1'b1;

    axis_1bit s0_if();
    axis_1bit s1_if();
    axis_1bit m_if();

    axis_1bit_frame_arbiter #(.OVERSAMPLE(OS), .IDLE_TIMEOUT(TO)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .s0_axis       (s0_if),
        .s1_axis       (s1_if),
        .m_axis        (m_if),
        .o_grant       (grant),
        .o_timeout_err (to_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Source beat queues {tlast, tdata}; head is what the source presents.
    logic [1:0] q0[$], q1[$];
    logic [1:0] sent0[$], sent1[$];
    logic [1:0] got0[$], got1[$];

    // Behavioural model: who owns the sink, beats taken in this grant,
    // consecutive silent cycles, and who wins the next contention.
    int m_owner = -1;
    int m_pref  = 0;
    int m_beats = 0;
    int m_quiet = 0;

    int cyc_n = 0, g0_cyc = 0, g1_cyc = 0, to_pulses = 0, to_cyc = 0;
    int st_cyc[$], st_own[$];
    logic [1:0] prev_grant = 2'b00;

    logic own_v, own_d, own_l, e_acc, e_fe, e_to;
    logic [7:0] exp_v, act_v;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    task automatic drive();
        s0_if.tvalid = (q0.size() > 0);
        s0_if.tdata  = (q0.size() > 0) ? q0[0][0] : 1'b0;
        s0_if.tlast  = (q0.size() > 0) ? q0[0][1] : 1'b0;
        s1_if.tvalid = (q1.size() > 0);
        s1_if.tdata  = (q1.size() > 0) ? q1[0][0] : 1'b0;
        s1_if.tlast  = (q1.size() > 0) ? q1[0][1] : 1'b0;
        m_if.tready  = rdy;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic load(input int src, input logic [15:0] data, input logic [15:0] last, input int n);
        for (int i = 0; i < n; i++) begin
            if (src == 0) begin
                q0.push_back({last[i], data[i]});
                sent0.push_back({last[i], data[i]});
            end else begin
                q1.push_back({last[i], data[i]});
                sent1.push_back({last[i], data[i]});
            end
        end
    endtask

    task automatic clr();
        got0.delete(); got1.delete(); sent0.delete(); sent1.delete();
        st_cyc.delete(); st_own.delete();
        g0_cyc = 0; g1_cyc = 0; to_pulses = 0; to_cyc = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q0.delete(); q1.delete();
        rdy = 1'b1;
        drive();
        cyc(); cyc();
        rst_n = 1'b1;
    endtask

    task automatic cmp_stream(input string name, input int src);
        if (src == 0) begin
            chk({name, "_count"}, got0.size(), sent0.size());
            for (int i = 0; i < sent0.size() && i < got0.size(); i++) chk(name, got0[i], sent0[i]);
        end else begin
            chk({name, "_count"}, got1.size(), sent1.size());
            for (int i = 0; i < sent1.size() && i < got1.size(); i++) chk(name, got1[i], sent1[i]);
        end
    endtask

    always @(negedge clk) begin
        cyc_n++;
        if (!rst_n) begin
            m_owner = -1; m_pref = 0; m_beats = 0; m_quiet = 0;
        end
        own_v = (m_owner == 0) ? s0_if.tvalid : (m_owner == 1) ? s1_if.tvalid : 1'b0;
        own_d = (m_owner == 0) ? s0_if.tdata  : (m_owner == 1) ? s1_if.tdata  : 1'b0;
        own_l = (m_owner == 0) ? s0_if.tlast  : (m_owner == 1) ? s1_if.tlast  : 1'b0;
        e_acc = (m_owner >= 0) && own_v && m_if.tready;
        e_fe  = e_acc && own_l && ((m_beats % OS) == OS - 1);
        e_to  = (m_owner >= 0) && !own_v && (m_quiet + 1 == TO);

        exp_v = {m_owner == 1, m_owner == 0, own_v, own_d & own_v, own_l & own_v,
                 (m_owner == 0) && m_if.tready, (m_owner == 1) && m_if.tready, e_to};
        act_v = {grant, m_if.tvalid, m_if.tdata & m_if.tvalid, m_if.tlast & m_if.tvalid,
                 s0_if.tready, s1_if.tready, to_err};
        chk("cycle_outputs", act_v, exp_v);

        if (s0_if.tvalid && s0_if.tready && q0.size() > 0) void'(q0.pop_front());
        if (s1_if.tvalid && s1_if.tready && q1.size() > 0) void'(q1.pop_front());
        if (m_if.tvalid && m_if.tready) begin
            if (m_owner == 0) got0.push_back({m_if.tlast, m_if.tdata});
            if (m_owner == 1) got1.push_back({m_if.tlast, m_if.tdata});
        end

        if (grant == 2'b01) g0_cyc++;
        if (grant == 2'b10) g1_cyc++;
        if (to_err === 1'b1) begin to_pulses++; to_cyc = cyc_n; end
        if (grant != 2'b00 && prev_grant == 2'b00) begin
            st_cyc.push_back(cyc_n);
            st_own.push_back((grant == 2'b10) ? 1 : 0);
        end
        prev_grant = grant;

        if (rst_n) begin
            if (m_owner < 0) begin
                if (s0_if.tvalid && s1_if.tvalid) m_owner = m_pref;
                else if (s0_if.tvalid)            m_owner = 0;
                else if (s1_if.tvalid)            m_owner = 1;
                m_beats = 0;
                m_quiet = 0;
            end else begin
                if (e_acc) m_beats++;
                m_quiet = own_v ? 0 : m_quiet + 1;
                if (e_fe || e_to) begin
                    m_pref  = 1 - m_owner;
                    m_owner = -1;
                end
            end
        end
    end

    initial begin
        int hold;
        drive();
        rst_n = 1'b0;
        cyc(); cyc();
        chk("rst_grant", grant, 0);
        chk("rst_mvalid", m_if.tvalid, 0);
        chk("rst_tready", {s0_if.tready, s1_if.tready}, 0);
        chk("rst_timeout", to_err, 0);
        rst_n = 1'b1;

        // s0 alone: 3 symbols, tlast on beats 9-12
        clr();
        load(0, 16'h0B2D, 16'h0F00, 12);
        run(16);
        chk("t1_grant0_cycles", g0_cyc, 12);
        chk("t1_grant1_cycles", g1_cyc, 0);
        chk("t1_grants", st_own.size(), 1);
        chk("t1_idle_after", grant, 0);
        cmp_stream("t1_s0_data", 0);

        // both pending from reset: s0, s1, s0, s1 with one bubble each
        do_reset();
        clr();
        load(0, 16'h000A, 16'h0008, 4); load(0, 16'h0003, 16'h0008, 4);
        load(1, 16'h0006, 16'h0008, 4); load(1, 16'h0009, 16'h0008, 4);
        run(24);
        chk("t2_grants", st_own.size(), 4);
        if (st_own.size() == 4) begin
            chk("t2_order0", st_own[0], 0);
            chk("t2_order1", st_own[1], 1);
            chk("t2_order2", st_own[2], 0);
            chk("t2_order3", st_own[3], 1);
            chk("t2_bubble", st_cyc[1] - st_cyc[0], 5);
        end
        cmp_stream("t2_s0_data", 0);
        cmp_stream("t2_s1_data", 1);

        // s1 tlast only mid-symbol first, real end at beat 8
        clr();
        load(1, 16'h00C5, 16'h0082, 8);
        run(12);
        chk("t3_grants", st_own.size(), 1);
        chk("t3_grant1_cycles", g1_cyc, 8);
        cmp_stream("t3_s1_data", 1);

        // s0 goes silent after 4 beats, s1 waiting
        do_reset();
        clr();
        load(0, 16'h0005, 16'h0000, 4);
        load(1, 16'h000C, 16'h0008, 4);
        run(80);
        chk("t4_timeout_pulses", to_pulses, 1);
        chk("t4_grant0_cycles", g0_cyc, 68);
        chk("t4_grants", st_own.size(), 2);
        if (st_own.size() == 2) begin
            chk("t4_first", st_own[0], 0);
            chk("t4_second", st_own[1], 1);
            chk("t4_to_delay", to_cyc - st_cyc[0], 67);
            chk("t4_regrant", st_cyc[1] - to_cyc, 2);
        end
        cmp_stream("t4_s1_data", 1);

        // s1 frame under random sink back-pressure
        clr();
        load(1, 16'h00D3, 16'h00F0, 8);
        hold = 0;
        for (int k = 0; k < 400 && (q1.size() > 0 || grant != 2'b00); k++) begin
            if (hold == 0) begin
                rdy  = ~rdy;
                hold = $urandom_range(1, 10);
            end
            hold--;
            cyc();
        end
        rdy = 1'b1;
        chk("t5_drain", q1.size(), 0);
        chk("t5_timeouts", to_pulses, 0);
        chk("t5_grants", st_own.size(), 1);
        cmp_stream("t5_s1_data", 1);

        // async reset during beat 6 of an s0 frame
        do_reset();
        clr();
        load(0, 16'h0B2D, 16'h0F00, 12);
        load(1, 16'h0009, 16'h0008, 4);
        cyc();
        run(6);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_grant", grant, 0);
        chk("t6_rst_mvalid", m_if.tvalid, 0);
        chk("t6_rst_tready", {s0_if.tready, s1_if.tready}, 0);
        chk("t6_rst_timeout", to_err, 0);
        q0.delete();
        cyc(); cyc();
        rst_n = 1'b1;
        st_cyc.delete(); st_own.delete();
        run(8);
        chk("t6_s0_beats", got0.size(), 5);
        chk("t6_grants", st_own.size(), 1);
        if (st_own.size() > 0) chk("t6_first_owner", st_own[0], 1);
        cmp_stream("t6_s1_data", 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
